// File: rtl/prism_pkg.sv
// Shared constants and types for the PRISM input path: widths, in_data bit map,
// register addresses and the per-bit filter decision encoding.
package prism_pkg;

   localparam int PRISM_IN_W   = 8;
   localparam int PRISM_FCNT_W = 4;

   // Positions of the conditioned pins inside the PRISM in_data word
   localparam int PRISM_IN_BIT_LO = 0;
   localparam int PRISM_IN_BIT_HI = PRISM_IN_BIT_LO + PRISM_IN_W - 1;

   localparam logic [7:0] PRISM_ADDR_IN_COND  = 8'h1C;
   localparam logic [7:0] PRISM_ADDR_IN_FLAGS = 8'h20;

   typedef enum logic [1:0] {
      FILT_HOLD   = 2'd0,
      FILT_COUNT  = 2'd1,
      FILT_ACCEPT = 2'd2
   } filt_act_e;

endpackage

// File: rtl/prism_in_filt_bit.sv
// One conditioned input bit: polarity sample, stability filter, edge pulses
// and sticky rise/fall flags with write-1-to-clear.
module prism_in_filt_bit
   import prism_pkg::*;
#(
   parameter int FCNT_W = PRISM_FCNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              raw_bit,
   input  logic              inv_bit,
   input  logic [FCNT_W-1:0] filt_len,
   input  logic              flag_clr,
   output logic              cond_out,
   output logic              rise_pulse,
   output logic              fall_pulse,
   output logic              rise_flag,
   output logic              fall_flag,
   output logic              flag_nxt
);

   logic              samp_r;
   logic              cond_r;
   logic [FCNT_W-1:0] cnt_r;
   logic              rise_pulse_r;
   logic              fall_pulse_r;
   logic              rise_flag_r;
   logic              fall_flag_r;

   filt_act_e         act_s;
   logic              rise_set_s;
   logic              fall_set_s;
   logic              rise_flag_nxt_s;
   logic              fall_flag_nxt_s;

   // Filter decision; >= lets a lowered filt_len take effect mid-count
   always_comb begin
      act_s = FILT_HOLD;
      if (samp_r == cond_r) begin
         act_s = FILT_HOLD;
      end else if (cnt_r >= filt_len) begin
         act_s = FILT_ACCEPT;
      end else begin
         act_s = FILT_COUNT;
      end
   end

   // Edge detection and flag next state; a set beats a same-cycle clear
   always_comb begin
      rise_set_s      = (act_s == FILT_ACCEPT) &&  samp_r;
      fall_set_s      = (act_s == FILT_ACCEPT) && !samp_r;
      rise_flag_nxt_s = rise_set_s | (rise_flag_r & ~flag_clr);
      fall_flag_nxt_s = fall_set_s | (fall_flag_r & ~flag_clr);
   end

   // Sample, counter, level, pulse and flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp_r       <= 1'b0;
         cond_r       <= 1'b0;
         cnt_r        <= '0;
         rise_pulse_r <= 1'b0;
         fall_pulse_r <= 1'b0;
         rise_flag_r  <= 1'b0;
         fall_flag_r  <= 1'b0;
      end else begin
         samp_r       <= raw_bit ^ inv_bit;
         rise_pulse_r <= rise_set_s;
         fall_pulse_r <= fall_set_s;
         rise_flag_r  <= rise_flag_nxt_s;
         fall_flag_r  <= fall_flag_nxt_s;
         case (act_s)
            FILT_HOLD:   cnt_r <= '0;
            FILT_COUNT:  cnt_r <= cnt_r + FCNT_W'(1);
            FILT_ACCEPT: begin
               cond_r <= samp_r;
               cnt_r  <= '0;
            end
            default:     cnt_r <= '0;
         endcase
      end
   end

   assign cond_out   = cond_r;
   assign rise_pulse = rise_pulse_r;
   assign fall_pulse = fall_pulse_r;
   assign rise_flag  = rise_flag_r;
   assign fall_flag  = fall_flag_r;
   assign flag_nxt   = rise_flag_nxt_s | fall_flag_nxt_s;

endmodule

// File: rtl/prism_in_cond.sv
// PRISM input conditioner: WIDTH independent filter slices plus a registered
// interrupt summary that tracks the flag registers without extra delay.
module prism_in_cond
   import prism_pkg::*;
#(
   parameter int WIDTH  = PRISM_IN_W,
   parameter int FCNT_W = PRISM_FCNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  raw_in,
   input  logic [WIDTH-1:0]  inv_mask,
   input  logic [FCNT_W-1:0] filt_len,
   input  logic [WIDTH-1:0]  flag_clr,
   output logic [WIDTH-1:0]  cond_out,
   output logic [WIDTH-1:0]  rise_pulse,
   output logic [WIDTH-1:0]  fall_pulse,
   output logic [WIDTH-1:0]  rise_flag,
   output logic [WIDTH-1:0]  fall_flag,
   output logic              any_flag
);

   logic [WIDTH-1:0] flag_nxt_s;
   logic             any_flag_r;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      prism_in_filt_bit #(.FCNT_W(FCNT_W)) u_bit (
         .clk        (clk),
         .rst_n      (rst_n),
         .raw_bit    (raw_in[i]),
         .inv_bit    (inv_mask[i]),
         .filt_len   (filt_len),
         .flag_clr   (flag_clr[i]),
         .cond_out   (cond_out[i]),
         .rise_pulse (rise_pulse[i]),
         .fall_pulse (fall_pulse[i]),
         .rise_flag  (rise_flag[i]),
         .fall_flag  (fall_flag[i]),
         .flag_nxt   (flag_nxt_s[i])
      );
   end

   // Interrupt summary built from the flags' next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_flag_r <= 1'b0;
      end else begin
         any_flag_r <= |flag_nxt_s;
      end
   end

   assign any_flag = any_flag_r;

endmodule

// File: tb/tb_prism_in_cond.sv
// Directed bench for prism_in_cond: latency, glitch rejection, filt_len rewrite,
// inversion, flag set/clear priority and asynchronous reset.
module tb_prism_in_cond;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] raw_in;
   logic [7:0] inv_mask;
   logic [3:0] filt_len;
   logic [7:0] flag_clr;
   logic [7:0] cond_out;
   logic [7:0] rise_pulse;
   logic [7:0] fall_pulse;
   logic [7:0] rise_flag;
   logic [7:0] fall_flag;
   logic       any_flag;

   int checks = 0;
   int errors = 0;

   prism_in_cond dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw_in     (raw_in),
      .inv_mask   (inv_mask),
      .filt_len   (filt_len),
      .flag_clr   (flag_clr),
      .cond_out   (cond_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .rise_flag  (rise_flag),
      .fall_flag  (fall_flag),
      .any_flag   (any_flag)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " cond"}, cond_out, 8'h00);
      check({tag, " rpulse"}, rise_pulse, 8'h00);
      check({tag, " fpulse"}, fall_pulse, 8'h00);
      check({tag, " rflag"}, rise_flag, 8'h00);
      check({tag, " fflag"}, fall_flag, 8'h00);
      check({tag, " any"}, {7'd0, any_flag}, 8'h00);
   endtask

   initial begin
      rst_n    = 1'b0;
      raw_in   = 8'h00;
      inv_mask = 8'h00;
      filt_len = 4'd0;
      flag_clr = 8'h00;
      #12;
      check_all_zero("reset");
      rst_n = 1'b1;
      tick(2);

      // filt_len 0: two-cycle passthrough on bit 0
      raw_in = 8'h01;
      tick(1);
      check("pass0 cond@1", cond_out, 8'h00);
      tick(1);
      check("pass0 cond@2", cond_out, 8'h01);
      check("pass0 rpulse", rise_pulse, 8'h01);
      check("pass0 rflag", rise_flag, 8'h01);
      check("pass0 any", {7'd0, any_flag}, 8'h01);
      tick(1);
      check("pass0 rpulse off", rise_pulse, 8'h00);
      check("pass0 rflag held", rise_flag, 8'h01);
      flag_clr = 8'h01;
      tick(1);
      flag_clr = 8'h00;
      check("clr0 rflag", rise_flag, 8'h00);
      check("clr0 any", {7'd0, any_flag}, 8'h00);

      // filt_len 3: 3-cycle glitch on bit 2 is rejected
      filt_len = 4'd3;
      raw_in = 8'h05;
      tick(3);
      raw_in = 8'h01;
      for (int k = 0; k < 6; k++) begin
         tick(1);
         check("glitch cond", cond_out, 8'h01);
         check("glitch rpulse", rise_pulse, 8'h00);
      end

      // 4-cycle level is accepted 5 cycles after the raw change
      raw_in = 8'h05;
      tick(4);
      check("lvl cond@4", cond_out, 8'h01);
      tick(1);
      check("lvl cond@5", cond_out, 8'h05);
      check("lvl rpulse", rise_pulse, 8'h04);
      flag_clr = 8'hFF;
      tick(1);
      flag_clr = 8'h00;

      // filt_len 15, counter reaches 10, then shortened to 4
      filt_len = 4'd15;
      raw_in = 8'h01;
      tick(11);
      check("len15 cond held", cond_out, 8'h05);
      filt_len = 4'd4;
      tick(1);
      check("len4 cond", cond_out, 8'h01);
      check("len4 fpulse", fall_pulse, 8'h04);
      check("len4 fflag", fall_flag, 8'h04);
      flag_clr = 8'hFF;
      tick(1);
      flag_clr = 8'h00;
      check("clrall any", {7'd0, any_flag}, 8'h00);

      // Bit 5: clear in the same cycle as a new fall
      filt_len = 4'd0;
      raw_in = 8'h21;
      tick(2);
      check("b5 rflag", rise_flag, 8'h20);
      raw_in = 8'h01;
      tick(1);
      flag_clr = 8'h20;
      tick(1);
      flag_clr = 8'h00;
      check("b5 setclr rflag", rise_flag, 8'h00);
      check("b5 setclr fflag", fall_flag, 8'h20);
      check("b5 setclr any", {7'd0, any_flag}, 8'h01);
      tick(1);
      check("b5 fflag held", fall_flag, 8'h20);
      flag_clr = 8'h20;
      tick(1);
      flag_clr = 8'h00;
      check("b5 clr rflag", rise_flag, 8'h00);
      check("b5 clr fflag", fall_flag, 8'h00);
      check("b5 clr any", {7'd0, any_flag}, 8'h00);

      // Asynchronous reset while bit 1 is mid-count and a flag is set
      raw_in = 8'h09;
      tick(2);
      check("pre-rst rflag", rise_flag, 8'h08);
      filt_len = 4'd3;
      raw_in = 8'h0B;
      tick(3);
      check("pre-rst cond", cond_out, 8'h09);
      rst_n = 1'b0;
      #1;
      check_all_zero("async rst");
      #1;
      rst_n = 1'b1;
      tick(4);
      check("post-rst cond@4", cond_out, 8'h00);
      tick(1);
      check("post-rst cond@5", cond_out, 8'h0B);
      check("post-rst rpulse", rise_pulse, 8'h0B);
      check("post-rst rflag", rise_flag, 8'h0B);

      // Full inversion with raw held low from reset
      rst_n = 1'b0;
      raw_in = 8'h00;
      inv_mask = 8'hFF;
      filt_len = 4'd2;
      #2;
      check_all_zero("inv rst");
      rst_n = 1'b1;
      tick(3);
      check("inv cond@3", cond_out, 8'h00);
      tick(1);
      check("inv cond@4", cond_out, 8'hFF);
      check("inv rpulse", rise_pulse, 8'hFF);
      check("inv rflag", rise_flag, 8'hFF);
      check("inv fflag", fall_flag, 8'h00);
      check("inv any", {7'd0, any_flag}, 8'h01);
      tick(1);
      check("inv rpulse off", rise_pulse, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prism_in_cond.md
Name: prism_in_cond

Overview:
- Per-bit input conditioner upstream of the PRISM peripheral.
- Takes the synchronized ui_in pins and applies a per-bit polarity inversion and a programmable glitch filter (stability counter).
- Provides clean levels for PRISM in_data, one-cycle edge pulses, and sticky edge flags that the host reads and clears through the peripheral register file.
- Configuration inputs come from a host-writable register in the parent peripheral.

Parameters:
- WIDTH, 8, number of conditioned input bits
- FCNT_W, 4, width of the filter length and per-bit stability counter

Ports:
- clk  input  1  peripheral clock (64 MHz nominal)
- rst_n  input  1  reset
- raw_in  input  WIDTH  synchronized pin inputs
- inv_mask  input  WIDTH  1 = invert that bit before filtering
- filt_len  input  FCNT_W  stability cycles required beyond the first differing sample
- flag_clr  input  WIDTH  one-cycle write-1-to-clear strobe for the rise/fall flags of that bit
- cond_out  output  WIDTH  filtered, polarity-corrected levels
- rise_pulse  output  WIDTH  one-cycle pulse when cond_out bit goes 0->1
- fall_pulse  output  WIDTH  one-cycle pulse when cond_out bit goes 1->0
- rise_flag  output  WIDTH  sticky rise indication
- fall_flag  output  WIDTH  sticky fall indication
- any_flag  output  1  OR of all rise_flag and fall_flag bits (interrupt source)

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- On reset, all of the following clear to 0: samp, cnt, cond_out, the pulses, the flags and any_flag.
- Stage 1, sample register:
  - samp[i] <= raw_in[i] ^ inv_mask[i] every cycle.
- Stage 2, per-bit filter with counter cnt[i] (FCNT_W bits):
  - If samp[i] == cond_out[i]: cnt[i] <= 0.
  - Else if cnt[i] >= filt_len: cond_out[i] <= samp[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i] + 1.
  - The >= compare makes a lowered filt_len mid-count take effect on the next cycle. cnt never exceeds filt_len, so it never wraps.
- Latency and acceptance:
  - A clean level change on raw_in appears on cond_out filt_len+2 cycles later.
  - filt_len = 0 gives 2-cycle passthrough.
  - A disagreeing sample is accepted only after filt_len+1 consecutive differing samples.
  - Any agreeing sample restarts the count.
- Pulses are combinational-free registered outputs:
  - rise_pulse[i] = 1 for exactly the cycle after cond_out[i] rises.
  - fall_pulse[i] likewise for a fall.
  - Implementation: registered from the stage-2 update decision, so each pulse is coincident with the new cond_out value.
- Flags:
  - rise_flag[i] sets in the same cycle rise_pulse[i] is high; fall_flag[i] likewise.
  - flag_clr[i] clears both flags of bit i.
  - A set and a clear in the same cycle leave the flag set (set wins, so no event is lost).
- any_flag is registered: it is the OR of the flag registers' next state, so it tracks the flags with no extra cycle.
- inv_mask change: a changed mask bit changes samp, which the filter treats as a normal edge (filtered, flagged). No special bypass.
- Bits are fully independent; simultaneous edges on several bits all flag in the same cycle.
- Reset asserted mid-count discards the count, the levels and the flags immediately.

Decomposition:
- Package prism_pkg holds:
  - PRISM_IN_W = 8, PRISM_FCNT_W = 4
  - the bit-index localparams used by the parent to map cond_out into in_data
  - the register address of the conditioner config (0x1C) and flags (0x20)
- One sub-module, prism_in_filt_bit: a single-bit sample/counter/edge/flag slice, generated WIDTH times. The top module only ORs any_flag.

Test Plan:
- Reset, then raw_in = 0x00 -> 0x01, filt_len = 0 -> cond_out[0] = 1 exactly 2 cycles after the raw change; rise_pulse[0] high 1 cycle; rise_flag[0] = 1; any_flag = 1.
- filt_len = 3, 3-cycle glitch on raw_in[2] -> cond_out unchanged, no pulse. A 4-cycle level -> cond_out[2] rises 5 cycles after the raw change.
- filt_len = 15, counter at 10, then filt_len rewritten to 4 -> cond_out updates on the next cycle, cnt returns to 0.
- inv_mask = 0xFF with raw_in held at 0x00 from reset -> all cond_out rise after filt_len+2 cycles; rise_flag = 0xFF.
- Bit 5 rise flag set; flag_clr = 0x20 in the same cycle as a new fall on bit 5 -> rise_flag[5] = 0, fall_flag[5] = 1. Then flag_clr = 0x20 alone -> both flags 0 and any_flag = 0.
- rst_n pulsed low while cnt[1] = 2 and flags nonzero -> all outputs are 0 asynchronously. The next edge after reset requires a full filt_len+2 cycles.
